pong_game_engine: RTL and testbench

PONG_GAME_ENGINE -- requirements
Module: pong_game_engine

---
 rtl/pong_game_engine_if.sv | 34 +++
 rtl/pong_game_engine.sv | 273 +++++++++++++++++++++++++++
 tb/tb_pong_game_engine.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_engine_if.sv
// Pong engine bus: player inputs and the per-frame game state outputs.
//   start            level button, only its rising edge matters
//   stick_Y1/Y2      analog sticks, 128 = centre, >= 128 moves paddle up
//   ball_*_pos       ball top-left corner
//   player*_y_pos    paddle tops
//   player*_score    saturating scores
//   winner           0 none, 1 P1, 2 P2
//   state_out        current state code
// master drives the inputs (controller side), slave is the engine.
interface pong_game_engine_if;
    logic        start;
    logic [7:0]  stick_Y1;
    logic [7:0]  stick_Y2;
    logic [10:0] ball_x_pos;
    logic [10:0] ball_y_pos;
    logic [10:0] player1_y_pos;
    logic [10:0] player2_y_pos;
    logic [7:0]  player1_score;
    logic [7:0]  player2_score;
    logic [1:0]  winner;
    logic [2:0]  state_out;

    modport master (
        output start, stick_Y1, stick_Y2,
        input  ball_x_pos, ball_y_pos, player1_y_pos, player2_y_pos,
        input  player1_score, player2_score, winner, state_out
    );

    modport slave (
        input  start, stick_Y1, stick_Y2,
        output ball_x_pos, ball_y_pos, player1_y_pos, player2_y_pos,
        output player1_score, player2_score, winner, state_out
    );
endinterface

// File: rtl/pong_game_engine.sv
// Pong game engine, one update per vsync edge.
//   vsync  the only clock, one rising edge per frame
//   rst_n  asynchronous active-low reset
//   bus    pong_game_engine_if.slave (sticks/start in, ball/paddles/scores out)
// pong_paddle_step is the per-paddle combinational mover; the top holds all
// state in a single FSM register block so every output is registered.

module pong_paddle_step #(
    parameter int V_RES       = 480,
    parameter int PADDLE_H    = 100,
    parameter int STICK_SHIFT = 5
) (
    input  logic [7:0]  stick,
    input  logic [10:0] y,
    output logic [10:0] y_next,
    output logic [7:0]  d,
    output logic        up
);
    localparam logic [10:0] Y_MAX = 11'(V_RES - PADDLE_H);

    logic [7:0]  mag;
    logic [11:0] sum;

    always_comb begin
        up  = stick[7];                              // stick >= 128
        mag = up ? (stick - 8'd128) : (8'd128 - stick);
        d   = mag >> STICK_SHIFT;
        sum = {1'b0, y} + {4'b0, d};
        // Clamp before narrowing so neither direction can wrap.
        if (up)
            y_next = ({1'b0, y} >= {4'b0, d}) ? (y - 11'(d)) : '0;
        else
            y_next = (sum > {1'b0, Y_MAX}) ? Y_MAX : sum[10:0];
    end
endmodule

module pong_game_engine #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 10,
    parameter int PADDLE_H     = 100,
    parameter int PADDLE_W     = 5,
    parameter int SERVE_VX     = 8,
    parameter int SERVE_VY     = 3,
    parameter int MAX_VX       = 16,
    parameter int STICK_SHIFT  = 5,
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic              vsync,
    input  logic              rst_n,
    pong_game_engine_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam int              CW       = $clog2(PAUSE_FRAMES + 1);
    localparam logic [10:0]     BALL_X0  = 11'(H_RES / 2);
    localparam logic [10:0]     BALL_Y0  = 11'(V_RES / 2);
    localparam logic [10:0]     PAD_Y0   = 11'((V_RES - PADDLE_H) / 2);
    localparam logic [10:0]     X_HIT_L  = 11'(PADDLE_W);
    localparam logic [10:0]     X_HIT_R  = 11'(H_RES - PADDLE_W - BALL_SIZE);
    localparam logic [10:0]     Y_BOT    = 11'(V_RES - BALL_SIZE);
    localparam logic [CW-1:0]   PAUSE_LD = CW'(PAUSE_FRAMES - 1);
    localparam logic [7:0]      VX_MAX   = 8'(MAX_VX);
    localparam logic [7:0]      WIN      = 8'(WIN_SCORE);

    // Direction flags: x_right=0 is LEFT, y_up=0 is DOWN.
    state_t           state;
    logic             start_q, start_edge;
    logic             serve_right, x_right, y_up;
    logic [CW-1:0]    cnt;
    logic [7:0]       vx, vy;
    logic [10:0]      ball_x, ball_y;
    logic [1:0][10:0] pad_y, pad_nxt;
    logic [1:0][7:0]  stick, pad_d;
    logic [1:0]       pad_up;
    logic [7:0]       score1, score2;
    logic [1:0]       winner;

    assign start_edge = bus.start & ~start_q;
    assign stick[0]   = bus.stick_Y1;
    assign stick[1]   = bus.stick_Y2;

    for (genvar i = 0; i < 2; i++) begin : g_pad
        pong_paddle_step #(
            .V_RES(V_RES), .PADDLE_H(PADDLE_H), .STICK_SHIFT(STICK_SHIFT)
        ) u_step (
            .stick (stick[i]),
            .y     (pad_y[i]),
            .y_next(pad_nxt[i]),
            .d     (pad_d[i]),
            .up    (pad_up[i])
        );
    end

    // One ball step. All sums are 12 bits so edge comparisons never wrap;
    // overlap uses the paddle positions from before this frame's move.
    logic [11:0] bx, by, p1y, p2y, vxw, vyw;
    logic [10:0] nx, ny;
    logic [7:0]  nvx, nvy;
    logic        nx_right, ny_up, hit_l, hit_r, miss_l, miss_r;

    always_comb begin
        bx  = {1'b0, ball_x};
        by  = {1'b0, ball_y};
        p1y = {1'b0, pad_y[0]};
        p2y = {1'b0, pad_y[1]};
        vxw = {4'b0, vx};
        vyw = {4'b0, vy};

        ny    = ball_y;
        ny_up = y_up;
        if (!y_up && (by + 12'(BALL_SIZE) + vyw >= 12'(V_RES))) begin
            ny    = Y_BOT;
            ny_up = 1'b1;
        end else if (y_up && (by < vyw)) begin
            ny    = '0;
            ny_up = 1'b0;
        end else if (y_up) begin
            ny = ball_y - 11'(vy);
        end else begin
            ny = ball_y + 11'(vy);
        end

        nx       = ball_x;
        nx_right = x_right;
        nvx      = vx;
        nvy      = vy;
        hit_l    = 1'b0;
        hit_r    = 1'b0;
        miss_l   = 1'b0;
        miss_r   = 1'b0;
        if (!x_right && (bx < 12'(PADDLE_W) + vxw)) begin
            if ((by + 12'(BALL_SIZE) > p1y) && (by < p1y + 12'(PADDLE_H))) hit_l  = 1'b1;
            else                                                            miss_l = 1'b1;
        end else if (x_right && (bx + 12'(BALL_SIZE) + vxw > 12'(H_RES - PADDLE_W))) begin
            if ((by + 12'(BALL_SIZE) > p2y) && (by < p2y + 12'(PADDLE_H))) hit_r  = 1'b1;
            else                                                            miss_r = 1'b1;
        end else if (x_right) begin
            nx = ball_x + 11'(vx);
        end else begin
            nx = ball_x - 11'(vx);
        end

        // A paddle hit overrides the wall bounce's direction: the player's
        // stick steers the return.
        if (hit_l || hit_r) begin
            nx       = hit_l ? X_HIT_L : X_HIT_R;
            nx_right = hit_l;
            nvx      = (vx >= VX_MAX) ? VX_MAX : vx + 8'd1;
            ny_up    = pad_up[hit_r];
            nvy      = (pad_d[hit_r] != '0) ? pad_d[hit_r] : vy;
        end
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge vsync or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            cnt         <= '0;
            serve_right <= 1'b0;
            vx          <= '0;
            vy          <= '0;
            x_right     <= 1'b0;
            y_up        <= 1'b0;
            ball_x      <= BALL_X0;
            ball_y      <= BALL_Y0;
            pad_y       <= {PAD_Y0, PAD_Y0};
            score1      <= '0;
            score2      <= '0;
            winner      <= '0;
        end else begin
            start_q <= bus.start;
            case (state)
                IDLE: begin
                    ball_x <= BALL_X0;
                    ball_y <= BALL_Y0;
                    pad_y  <= {PAD_Y0, PAD_Y0};
                    score1 <= '0;
                    score2 <= '0;
                    winner <= '0;
                    if (start_edge) begin
                        state       <= SERVE;
                        cnt         <= PAUSE_LD;
                        serve_right <= 1'b0;
                    end
                end
                SERVE: begin
                    ball_x <= BALL_X0;
                    ball_y <= BALL_Y0;
                    pad_y  <= pad_nxt;
                    if (cnt == '0) begin
                        state   <= PLAY;
                        vx      <= 8'(SERVE_VX);
                        vy      <= 8'(SERVE_VY);
                        y_up    <= 1'b0;
                        x_right <= serve_right;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PLAY: begin
                    pad_y   <= pad_nxt;
                    ball_x  <= nx;
                    ball_y  <= ny;
                    x_right <= nx_right;
                    y_up    <= ny_up;
                    vx      <= nvx;
                    vy      <= nvy;
                    // The loser receives the next serve.
                    if (miss_l) begin
                        score2      <= sat_inc(score2);
                        serve_right <= 1'b0;
                        state       <= POINT;
                        cnt         <= PAUSE_LD;
                    end else if (miss_r) begin
                        score1      <= sat_inc(score1);
                        serve_right <= 1'b1;
                        state       <= POINT;
                        cnt         <= PAUSE_LD;
                    end
                end
                POINT: begin
                    if (score1 == WIN) begin
                        state  <= GAME_OVER;
                        winner <= 2'd1;
                    end else if (score2 == WIN) begin
                        state  <= GAME_OVER;
                        winner <= 2'd2;
                    end else if (cnt == '0) begin
                        state  <= SERVE;
                        cnt    <= PAUSE_LD;
                        ball_x <= BALL_X0;
                        ball_y <= BALL_Y0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAME_OVER: begin
                    if (start_edge) begin
                        state  <= IDLE;
                        ball_x <= BALL_X0;
                        ball_y <= BALL_Y0;
                        pad_y  <= {PAD_Y0, PAD_Y0};
                        score1 <= '0;
                        score2 <= '0;
                        winner <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ball_x_pos    = ball_x;
    assign bus.ball_y_pos    = ball_y;
    assign bus.player1_y_pos = pad_y[0];
    assign bus.player2_y_pos = pad_y[1];
    assign bus.player1_score = score1;
    assign bus.player2_score = score2;
    assign bus.winner        = winner;
    assign bus.state_out     = state;
endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine: a frame-level game model predicts every output
// after each vsync edge (queued when the frame is driven, compared after the
// edge), plus directed checks on the key numbers: reset values, serve timing,
// paddle step/clamp, point pause, win and async reset mid-play.
module tb_pong_game_engine;
    logic vsync = 1'b0;
    logic rst_n;

    pong_game_engine_if bus ();

    pong_game_engine dut (
        .vsync(vsync),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 vsync = ~vsync;

    typedef struct packed {
        logic [10:0] bx;
        logic [10:0] by;
        logic [10:0] p1;
        logic [10:0] p2;
        logic [7:0]  s1;
        logic [7:0]  s2;
        logic [1:0]  win;
        logic [2:0]  st;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    // Game model state
    int m_st, m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_win, m_cnt;
    int m_vx, m_vy, m_srv_r, m_xr, m_yu, m_sq;

    function automatic int defl(input int s);
        return ((s >= 128) ? s - 128 : 128 - s) >> 5;
    endfunction

    function automatic int mv(input int y, input int s);
        int d;
        d = defl(s);
        if (s >= 128) return (y - d < 0) ? 0 : y - d;
        return (y + d > 380) ? 380 : y + d;
    endfunction

    task automatic model_idle();
        m_bx = 320; m_by = 240; m_p1 = 190; m_p2 = 190;
        m_s1 = 0; m_s2 = 0; m_win = 0;
    endtask

    task automatic model_reset();
        model_idle();
        m_st = 0; m_cnt = 0; m_srv_r = 0; m_vx = 0; m_vy = 0;
        m_xr = 0; m_yu = 0; m_sq = 0;
    endtask

    task automatic model_edge(input bit st, input int s1, input int s2);
        bit se;
        int o1, o2, ny, nyu;
        se   = st && !m_sq;
        m_sq = st;
        case (m_st)
            0: begin
                model_idle();
                if (se) begin m_st = 1; m_cnt = 59; m_srv_r = 0; end
            end
            1: begin
                m_bx = 320; m_by = 240;
                m_p1 = mv(m_p1, s1); m_p2 = mv(m_p2, s2);
                if (m_cnt == 0) begin
                    m_st = 2; m_vx = 8; m_vy = 3; m_yu = 0; m_xr = m_srv_r;
                end else m_cnt--;
            end
            2: begin
                o1 = m_p1; o2 = m_p2;
                m_p1 = mv(o1, s1); m_p2 = mv(o2, s2);
                nyu = m_yu;
                if (!m_yu && m_by + 10 + m_vy >= 480) begin ny = 470; nyu = 1; end
                else if (m_yu && m_by < m_vy)         begin ny = 0;   nyu = 0; end
                else ny = m_yu ? m_by - m_vy : m_by + m_vy;
                if (!m_xr && m_bx < 5 + m_vx) begin
                    if (m_by + 10 > o1 && m_by < o1 + 100) begin
                        m_bx = 5; m_xr = 1; m_vx = (m_vx + 1 > 16) ? 16 : m_vx + 1;
                        nyu = (s1 >= 128);
                        if (defl(s1) != 0) m_vy = defl(s1);
                    end else begin
                        m_s2 = (m_s2 == 255) ? 255 : m_s2 + 1;
                        m_srv_r = 0; m_st = 3; m_cnt = 59;
                    end
                end else if (m_xr && m_bx + 10 + m_vx > 635) begin
                    if (m_by + 10 > o2 && m_by < o2 + 100) begin
                        m_bx = 625; m_xr = 0; m_vx = (m_vx + 1 > 16) ? 16 : m_vx + 1;
                        nyu = (s2 >= 128);
                        if (defl(s2) != 0) m_vy = defl(s2);
                    end else begin
                        m_s1 = (m_s1 == 255) ? 255 : m_s1 + 1;
                        m_srv_r = 1; m_st = 3; m_cnt = 59;
                    end
                end else m_bx = m_xr ? m_bx + m_vx : m_bx - m_vx;
                m_by = ny; m_yu = nyu;
            end
            3: begin
                if (m_s1 == 7)      begin m_st = 4; m_win = 1; end
                else if (m_s2 == 7) begin m_st = 4; m_win = 2; end
                else if (m_cnt == 0) begin m_st = 1; m_cnt = 59; m_bx = 320; m_by = 240; end
                else m_cnt--;
            end
            4: if (se) begin m_st = 0; model_idle(); end
            default: m_st = 0;
        endcase
    endtask

    function automatic obs_t m_obs();
        obs_t o;
        o.bx = 11'(m_bx); o.by = 11'(m_by); o.p1 = 11'(m_p1); o.p2 = 11'(m_p2);
        o.s1 = 8'(m_s1);  o.s2 = 8'(m_s2);  o.win = 2'(m_win); o.st = 3'(m_st);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.bx = bus.ball_x_pos;    o.by = bus.ball_y_pos;
        o.p1 = bus.player1_y_pos; o.p2 = bus.player2_y_pos;
        o.s1 = bus.player1_score; o.s2 = bus.player2_score;
        o.win = bus.winner;       o.st = bus.state_out;
        return o;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    // Drive one frame's inputs, queue the model's prediction, compare after the edge.
    task automatic frame(input bit st, input int s1, input int s2);
        obs_t got, exp;
        @(negedge vsync);
        bus.start = st; bus.stick_Y1 = 8'(s1); bus.stick_Y2 = 8'(s2);
        model_edge(st, s1, s2);
        exp_q.push_back(m_obs());
        @(posedge vsync);
        #1;
        got = dut_obs();
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL frame: got %p required %p", got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bx"}, bus.ball_x_pos, 320);
        check({tag, "_by"}, bus.ball_y_pos, 240);
        check({tag, "_p1"}, bus.player1_y_pos, 190);
        check({tag, "_p2"}, bus.player2_y_pos, 190);
        check({tag, "_sc"}, bus.player1_score + bus.player2_score, 0);
        check({tag, "_win"}, bus.winner, 0);
        check({tag, "_st"}, bus.state_out, 0);
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.stick_Y1 = 8'd128; bus.stick_Y2 = 8'd128;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_reset_vals("reset");
        @(negedge vsync);
        rst_n = 1'b1;
        repeat (3) frame(0, 128, 128);

        // Held start: one transition; paddles move from the second frame on.
        repeat (5) frame(1, 255, 0);
        check("serve_state", bus.state_out, 1);
        check("p1_step3", bus.player1_y_pos, 178);
        check("p2_step4", bus.player2_y_pos, 206);
        n = 4;
        while (bus.state_out != 3'd2 && n < 200) begin frame(0, 255, 0); n++; end
        check("serve_frames", n, 60);
        check("p2_clamp", bus.player2_y_pos, 380);
        check("p1_at_play", bus.player1_y_pos, 10);

        // First PLAY frame; start pulse must be ignored here.
        frame(1, 255, 0);
        check("play_bx", bus.ball_x_pos, 312);
        check("play_by", bus.ball_y_pos, 243);
        check("play_ignores_start", bus.state_out, 2);
        repeat (3) frame(0, 255, 0);
        check("p1_clamp", bus.player1_y_pos, 0);

        // Rally A: P1 paddle parked at the top misses.
        n = 0;
        while (bus.state_out != 3'd3 && n < 200) begin frame(0, 255, 0); n++; end
        check("a_p2_score", bus.player2_score, 1);
        check("a_p1_score", bus.player1_score, 0);
        n = 0;
        while (bus.state_out != 3'd1 && n < 200) begin frame(n == 10, 32, 255); n++; end
        check("point_frames", n, 60);

        // Rally B: P1 returns, P2 parked at the top misses.
        n = 0;
        while (bus.state_out != 3'd3 && n < 400) begin frame(0, 32, 255); n++; end
        check("b_p1_score", bus.player1_score, 1);
        check("b_p2_score", bus.player2_score, 1);

        // Next serve goes right (toward the player who lost the point).
        n = 0;
        while (bus.state_out != 3'd2 && n < 300) begin frame(0, 255, 32); n++; end
        frame(0, 255, 32);
        check("serve_right_bx", bus.ball_x_pos, 328);

        // Play on until P2 reaches the winning score.
        n = 0;
        while (bus.state_out != 3'd4 && n < 3000) begin frame(0, 255, 32); n++; end
        check("go_state", bus.state_out, 4);
        check("go_winner", bus.winner, 2);
        check("go_p2_score", bus.player2_score, 7);
        check("go_p1_score", bus.player1_score, 1);
        repeat (3) frame(0, 128, 128);
        frame(1, 128, 128);
        check("idle_after_go", bus.state_out, 0);
        check("idle_score_clr", bus.player2_score, 0);
        check("idle_win_clr", bus.winner, 0);

        // New game, then async reset between edges mid-PLAY.
        frame(0, 128, 128);
        frame(1, 200, 60);
        n = 0;
        while (bus.state_out != 3'd2 && n < 200) begin frame(0, 200, 60); n++; end
        repeat (5) frame(0, 200, 60);
        @(posedge vsync);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_vals("async_rst");
        #20;
        check("rst_hold_st", bus.state_out, 0);
        @(negedge vsync);
        rst_n = 1'b1;
        repeat (3) frame(0, 128, 128);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
